// File: rtl/block_convolutional_encoder.sv
// Rate-1/2 convolutional encoder: serialises a SIZE_IN-bit payload MSB first and packs {g0,g1} symbols.
// Define CONV_ENC_CONT_STATE_EN to keep the encoder history across frames (streaming code).
module block_convolutional_encoder #(
    parameter int             SIZE_IN = 8,
    parameter int             K       = 3,
    parameter logic [K-1:0]   G0      = 3'b111,
    parameter logic [K-1:0]   G1      = 3'b101
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [SIZE_IN-1:0]     i_data,
    output logic [2*SIZE_IN-1:0]   o_data,
    output logic                   o_valid,
    output logic                   o_busy
);

    localparam int SIZE_OUT = 2 * SIZE_IN;
    localparam int CNT_W    = $clog2(SIZE_IN + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ENC  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]          state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [SIZE_IN-1:0]  payload;
    logic [K-2:0]        hist;
    logic [SIZE_OUT-1:0] pack;

    logic         cur_bit;
    logic [K-1:0] tap;
    logic         g0;
    logic         g1;

    always_comb begin
        cur_bit = payload[SIZE_IN-1];
        tap     = {cur_bit, hist};
        g0      = ^(tap & G0);
        g1      = ^(tap & G1);
    end

    assign o_busy = (state != IDLE);

    // NOTE: every register here is cleared by reset, including the payload and pack
    // registers, so an aborted frame leaves nothing behind; all state uses <=.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            payload <= '0;
            hist    <= '0;
            pack    <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        payload <= i_data;
                        bit_cnt <= '0;
`ifdef CONV_ENC_CONT_STATE_EN
                        hist    <= hist;
`else
                        hist    <= '0;
`endif
                        state   <= ENC;
                    end
                end
                ENC: begin
                    payload <= payload << 1;
                    // Upper K-1 taps are {b, h[K-2:1]}: the history after shifting b in.
                    hist    <= tap[K-1:1];
                    pack    <= {pack[SIZE_OUT-3:0], g0, g1};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(SIZE_IN - 1))
                        state <= DONE;
                end
                DONE: begin
                    o_data  <= pack;
                    o_valid <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
